// File: rtl/enemy_wave_scheduler_if.sv
// Signal bundle between the game FSM / arrow bank and the wave scheduler.
interface enemy_wave_scheduler_if #(
  parameter int NUM_ARROWS = 8,
  parameter int SLOT_W = 3,
  parameter int CW = $clog2(NUM_ARROWS + 1)
);
  logic [3:0] state_in;
  logic [CW-1:0] pat_count_in;
  logic [NUM_ARROWS*SLOT_W-1:0] pat_timing_in;
  logic [NUM_ARROWS*2-1:0] pat_dir_in;
  logic [NUM_ARROWS-1:0] arrow_blocked_in;
  logic [NUM_ARROWS-1:0] arrow_hit_in;
  logic [NUM_ARROWS-1:0] spawn_out;
  logic [1:0] spawn_dir_out;
  logic busy_out;
  logic finished_out;
  logic damage_out;
  logic [CW-1:0] damage_count_out;
  logic [CW-1:0] blocked_count_out;

  modport master (
    output state_in, pat_count_in, pat_timing_in,
    output pat_dir_in, arrow_blocked_in, arrow_hit_in,
    input spawn_out, spawn_dir_out, busy_out,
    input finished_out, damage_out,
    input damage_count_out, blocked_count_out
  );

  modport slave (
    input state_in, pat_count_in, pat_timing_in,
    input pat_dir_in, arrow_blocked_in, arrow_hit_in,
    output spawn_out, spawn_dir_out, busy_out,
    output finished_out, damage_out,
    output damage_count_out, blocked_count_out
  );
endinterface

// File: rtl/enemy_wave_scheduler.sv
// Enemy-phase arrow wave: timed spawns, per-arrow resolution, completion.
module enemy_wave_scheduler #(
  parameter int NUM_ARROWS = 8,
  parameter int SLOT_W = 3,
  parameter int TICK_DIV = 32500000,
  parameter logic [3:0] PHASE_STATE = 4'b1000,
  parameter int CW = $clog2(NUM_ARROWS + 1)
) (
  input logic clk,
  input logic rst,
  enemy_wave_scheduler_if.slave bus
);
  localparam int TW = $clog2((2**SLOT_W - 1) * TICK_DIV + 1);
  localparam int TBITS = NUM_ARROWS * SLOT_W;

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT, SPAWN, DRAIN
  } state_t;

  state_t state, nxt;

  logic [3:0] prev_state;
  logic [TBITS-1:0] timing_q;
  logic [NUM_ARROWS*2-1:0] dir_q;
  logic [CW-1:0] n_q, idx, blk_cnt, dmg_cnt;
  logic [NUM_ARROWS-1:0] need_q, armed, resolved;
  logic [TW-1:0] cnt, target;
  logic finished, damage;

  logic in_phase, phase_start, abort;
  logic tick_done, all_done, do_spawn;
  logic [SLOT_W-1:0] t_cur;
  logic [1:0] d_cur;
  logic [NUM_ARROWS-1:0] onehot, new_blk, new_hit;

  function automatic logic [CW-1:0] eff_count(
    input logic [CW-1:0] c,
    input logic [TBITS-1:0] t
  );
    logic [CW-1:0] n;
    logic stop;
    n = '0;
    stop = 1'b0;
    for (int i = 0; i < NUM_ARROWS; i++) begin
      if (!stop && CW'(i) < c &&
          t[i*SLOT_W +: SLOT_W] != '0)
        n = CW'(i + 1);
      else
        stop = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [NUM_ARROWS-1:0] low_mask(
    input logic [CW-1:0] n
  );
    logic [NUM_ARROWS-1:0] m;
    for (int i = 0; i < NUM_ARROWS; i++)
      m[i] = CW'(i) < n;
    return m;
  endfunction

  function automatic logic [CW-1:0] popcnt(
    input logic [NUM_ARROWS-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_ARROWS; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [CW-1:0] sat_add(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b,
    input logic [CW-1:0] lim
  );
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[CW-1:0];
  endfunction

  assign in_phase = bus.state_in == PHASE_STATE;
  assign phase_start = in_phase &&
                       prev_state != PHASE_STATE;
  assign abort = state != IDLE && !in_phase;

  always_comb begin
    t_cur = '0;
    d_cur = '0;
    onehot = '0;
    for (int i = 0; i < NUM_ARROWS; i++) begin
      if (idx == CW'(i)) begin
        t_cur = timing_q[i*SLOT_W +: SLOT_W];
        d_cur = dir_q[2*i +: 2];
        onehot[i] = 1'b1;
      end
    end
  end

  assign target = TW'(t_cur) * TW'(TICK_DIV);
  assign tick_done = cnt == target - TW'(1);
  assign do_spawn = state == SPAWN && !abort;

  // Shield wins when block and hit arrive together.
  assign new_blk = armed & ~resolved &
                   bus.arrow_blocked_in;
  assign new_hit = armed & ~resolved &
                   bus.arrow_hit_in &
                   ~bus.arrow_blocked_in;
  assign all_done =
    ((resolved | new_blk | new_hit) & need_q) == need_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (phase_start) nxt = LOAD;
        LOAD: nxt = (n_q == '0) ? DRAIN : WAIT;
        WAIT: if (tick_done) nxt = SPAWN;
        SPAWN:
          nxt = (idx + CW'(1) < n_q) ? WAIT : DRAIN;
        DRAIN: if (all_done) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy_out = state != IDLE;
    bus.spawn_out = '0;
    bus.spawn_dir_out = '0;
    if (do_spawn) begin
      bus.spawn_out = onehot;
      bus.spawn_dir_out = d_cur;
    end
  end

  assign bus.finished_out = finished;
  assign bus.damage_out = damage;
  assign bus.damage_count_out = dmg_cnt;
  assign bus.blocked_count_out = blk_cnt;

  // Reset leaves prev_state in-phase so a held phase cannot restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= PHASE_STATE;
      timing_q <= '0;
      dir_q <= '0;
      n_q <= '0;
      need_q <= '0;
      armed <= '0;
      resolved <= '0;
      idx <= '0;
      cnt <= '0;
      blk_cnt <= '0;
      dmg_cnt <= '0;
      finished <= 1'b0;
      damage <= 1'b0;
    end else begin
      prev_state <= bus.state_in;
      finished <= 1'b0;
      damage <= 1'b0;
      if (state == IDLE) begin
        if (phase_start) begin
          timing_q <= bus.pat_timing_in;
          dir_q <= bus.pat_dir_in;
          n_q <= eff_count(bus.pat_count_in,
                           bus.pat_timing_in);
          need_q <= low_mask(eff_count(
            bus.pat_count_in, bus.pat_timing_in));
          armed <= '0;
          resolved <= '0;
          blk_cnt <= '0;
          dmg_cnt <= '0;
        end
      end else if (!abort) begin
        resolved <= resolved | new_blk | new_hit;
        blk_cnt <= sat_add(blk_cnt,
                           popcnt(new_blk), n_q);
        dmg_cnt <= sat_add(dmg_cnt,
                           popcnt(new_hit), n_q);
        damage <= |new_hit;
        unique case (state)
          LOAD: begin
            cnt <= '0;
            idx <= '0;
          end
          WAIT: cnt <= cnt + TW'(1);
          SPAWN: begin
            armed <= armed | onehot;
            idx <= idx + CW'(1);
            cnt <= '0;
          end
          DRAIN: if (all_done) finished <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Scoreboard bench: driver queues expected pulses, monitor checks them.
module tb_enemy_wave_scheduler;
  localparam int NA = 8;
  localparam int SW = 3;
  localparam int TD = 4;
  localparam logic [3:0] PH = 4'b1000;
  localparam int CW = 4;

  typedef struct {
    int cyc;
    logic [NA-1:0] vec;
    logic [1:0] dir;
  } spawn_e;

  typedef struct {
    int cyc;
    logic [CW-1:0] blk;
    logic [CW-1:0] dmg;
  } fin_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  spawn_e sq[$];
  fin_e fq[$];
  int dq[$];

  enemy_wave_scheduler_if #(
    .NUM_ARROWS(NA), .SLOT_W(SW), .CW(CW)
  ) bus ();

  enemy_wave_scheduler #(
    .NUM_ARROWS(NA), .SLOT_W(SW),
    .TICK_DIV(TD), .PHASE_STATE(PH), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic oops(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=pulse want=none at cyc %0d",
             nm, cyc);
  endtask

  always @(negedge clk) begin
    if (bus.spawn_out != '0) begin
      if (sq.size() == 0) oops("unexpected_spawn");
      else begin
        spawn_e e;
        e = sq.pop_front();
        chk("spawn_cyc", cyc, e.cyc);
        chk("spawn_vec", 32'(bus.spawn_out), 32'(e.vec));
        chk("spawn_dir", 32'(bus.spawn_dir_out),
            32'(e.dir));
      end
    end
    if (bus.finished_out) begin
      if (fq.size() == 0) oops("unexpected_finish");
      else begin
        fin_e f;
        f = fq.pop_front();
        chk("fin_cyc", cyc, f.cyc);
        chk("fin_busy", 32'(bus.busy_out), 0);
        chk("fin_blk", 32'(bus.blocked_count_out),
            32'(f.blk));
        chk("fin_dmg", 32'(bus.damage_count_out),
            32'(f.dmg));
      end
    end
    if (bus.damage_out) begin
      if (dq.size() == 0) oops("unexpected_damage");
      else chk("damage_cyc", cyc, dq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  function automatic logic [NA*SW-1:0] mk_t(
    input int a, input int b, input int c);
    logic [2:0] x, y, z;
    x = 3'(a);
    y = 3'(b);
    z = 3'(c);
    return {15'd0, z, y, x};
  endfunction

  function automatic logic [NA*2-1:0] mk_d(
    input int a, input int b, input int c);
    logic [1:0] x, y, z;
    x = 2'(a);
    y = 2'(b);
    z = 2'(c);
    return {10'd0, z, y, x};
  endfunction

  task automatic push_s(input int c, input int i,
                        input int d);
    spawn_e e;
    e.cyc = c;
    e.vec = NA'(1) << i;
    e.dir = 2'(d);
    sq.push_back(e);
  endtask

  task automatic push_f(input int c, input int b,
                        input int d);
    fin_e f;
    f.cyc = c;
    f.blk = CW'(b);
    f.dmg = CW'(d);
    fq.push_back(f);
  endtask

  task automatic start(input int n,
                       input logic [NA*SW-1:0] t,
                       input logic [NA*2-1:0] d,
                       output int l);
    bus.pat_count_in = CW'(n);
    bus.pat_timing_in = t;
    bus.pat_dir_in = d;
    bus.state_in = PH;
    l = cyc + 1;
  endtask

  task automatic pulse(input int c,
                       input logic [NA-1:0] b,
                       input logic [NA-1:0] h);
    goto(c);
    bus.arrow_blocked_in = b;
    bus.arrow_hit_in = h;
    step();
    bus.arrow_blocked_in = '0;
    bus.arrow_hit_in = '0;
  endtask

  task automatic leave();
    bus.state_in = 4'b0000;
    step();
  endtask

  initial begin
    int l;
    bus.state_in = 4'b0000;
    bus.pat_count_in = '0;
    bus.pat_timing_in = '0;
    bus.pat_dir_in = '0;
    bus.arrow_blocked_in = '0;
    bus.arrow_hit_in = '0;
    repeat (3) step();
    chk("rst_busy", 32'(bus.busy_out), 0);
    chk("rst_spawn", 32'(bus.spawn_out), 0);
    chk("rst_fin", 32'(bus.finished_out), 0);
    chk("rst_dmg", 32'(bus.damage_out), 0);
    chk("rst_cnt", 32'({bus.damage_count_out,
                        bus.blocked_count_out}), 0);
    rst = 1'b0;
    step();

    // wave 1: timings 1,2,1 all blocked
    start(3, mk_t(1, 2, 1), mk_d(1, 2, 3), l);
    push_s(l + 5, 0, 1);
    push_s(l + 14, 1, 2);
    push_s(l + 19, 2, 3);
    push_f(l + 22, 3, 0);
    goto(l);
    chk("w1_busy_load", 32'(bus.busy_out), 1);
    pulse(l + 7, 8'b001, 8'b0);
    pulse(l + 16, 8'b010, 8'b0);
    pulse(l + 21, 8'b100, 8'b0);
    goto(l + 23);
    chk("w1_idle", 32'(bus.busy_out), 0);
    leave();

    // zero timing entry truncates the wave
    start(3, mk_t(2, 0, 3), mk_d(3, 1, 1), l);
    push_s(l + 9, 0, 3);
    push_f(l + 12, 1, 0);
    pulse(l + 11, 8'b001, 8'b0);
    goto(l + 25);
    leave();

    // block+hit together, hit on unspawned, repeat hit
    start(2, mk_t(1, 3, 0), mk_d(0, 2, 0), l);
    push_s(l + 5, 0, 0);
    push_s(l + 18, 1, 2);
    push_f(l + 21, 2, 0);
    pulse(l + 7, 8'b001, 8'b011);
    chk("w3_blk", 32'(bus.blocked_count_out), 1);
    chk("w3_dmg", 32'(bus.damage_count_out), 0);
    pulse(l + 9, 8'b0, 8'b001);
    chk("w3_dmg_again", 32'(bus.damage_count_out), 0);
    pulse(l + 20, 8'b010, 8'b0);
    goto(l + 22);
    leave();

    // two hits in one cycle
    start(2, mk_t(1, 1, 0), mk_d(2, 3, 0), l);
    push_s(l + 5, 0, 2);
    push_s(l + 10, 1, 3);
    push_f(l + 13, 0, 2);
    dq.push_back(l + 13);
    pulse(l + 12, 8'b0, 8'b011);
    goto(l + 15);
    leave();

    // abort after first spawn, then fresh wave
    start(3, mk_t(1, 1, 1), mk_d(1, 1, 1), l);
    push_s(l + 5, 0, 1);
    dq.push_back(l + 7);
    pulse(l + 6, 8'b0, 8'b001);
    chk("ab_busy_before", 32'(bus.busy_out), 1);
    bus.state_in = 4'b0000;
    step();
    chk("ab_busy", 32'(bus.busy_out), 0);
    chk("ab_dmg_held", 32'(bus.damage_count_out), 1);
    goto(l + 20);
    chk("ab_dmg_held2", 32'(bus.damage_count_out), 1);
    start(1, mk_t(1, 0, 0), mk_d(2, 0, 0), l);
    push_s(l + 5, 0, 2);
    push_f(l + 8, 1, 0);
    goto(l);
    chk("re_busy", 32'(bus.busy_out), 1);
    chk("re_dmg_clr", 32'(bus.damage_count_out), 0);
    pulse(l + 7, 8'b001, 8'b0);
    goto(l + 9);
    leave();

    // reset mid-wave with phase held
    start(3, mk_t(1, 1, 1), mk_d(3, 3, 3), l);
    push_s(l + 5, 0, 3);
    pulse(l + 6, 8'b001, 8'b0);
    chk("rs_blk_pre", 32'(bus.blocked_count_out), 1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rs_busy", 32'(bus.busy_out), 0);
    chk("rs_blk", 32'(bus.blocked_count_out), 0);
    chk("rs_fin", 32'(bus.finished_out), 0);
    goto(l + 30);
    chk("rs_no_restart", 32'(bus.busy_out), 0);
    leave();
    start(1, mk_t(2, 0, 0), mk_d(1, 0, 0), l);
    push_s(l + 9, 0, 1);
    push_f(l + 12, 1, 0);
    goto(l);
    chk("rs_reentry", 32'(bus.busy_out), 1);
    pulse(l + 11, 8'b001, 8'b0);
    goto(l + 16);
    leave();

    chk("left_spawns", sq.size(), 0);
    chk("left_fins", fq.size(), 0);
    chk("left_dmg", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
